// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Tracks tag/valid per line, drives the external data array and main memory, counts hits/misses.
module cache_controller #(
    parameter int INDEX      = 3,
    parameter int CACHESIZE  = 8,
    parameter int MEMORYBITS = 5,
    parameter int CNTBITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [MEMORYBITS-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic [INDEX-1:0]      cache_addr,
    output logic [31:0]           cache_wdata,
    output logic                  cache_we,
    input  logic [31:0]           cache_rdata,
    output logic [MEMORYBITS-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic [CNTBITS-1:0]    hit_count,
    output logic [CNTBITS-1:0]    miss_count,
    output logic [2:0]            dbg_state
);

    localparam int TAG = MEMORYBITS - INDEX;
    localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

    // dbg_state encoding: IDLE=0 LOOKUP=1 MEM_RD=2 FILL=3 DONE=4
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [MEMORYBITS-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           fill_buf_q, fill_buf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic [CNTBITS-1:0]    hit_q, hit_d;
    logic [CNTBITS-1:0]    miss_q, miss_d;
    logic [CACHESIZE-1:0]  valid_q;
    logic [TAG-1:0]        tag_q [CACHESIZE];
    logic                  fill_en;

    logic [INDEX-1:0]      lat_idx;
    logic [TAG-1:0]        lat_tag;
    logic                  hit;

    assign lat_idx = addr_q[INDEX-1:0];
    assign lat_tag = addr_q[MEMORYBITS-1:INDEX];
    assign hit     = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        fill_buf_d  = fill_buf_q;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        ready_d     = (state_q == S_DONE);
        cache_we    = 1'b0;
        cache_wdata = wdata_q;
        mem_we      = 1'b0;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (we_q) begin
                    // Stores always go to memory; the line is only updated if already present.
                    mem_we  = 1'b1;
                    state_d = S_DONE;
                    if (hit) begin
                        cache_we = 1'b1;
                        hit_d    = sat_inc(hit_q);
                    end else begin
                        miss_d = sat_inc(miss_q);
                    end
                end else if (hit) begin
                    rdata_d = cache_rdata;
                    hit_d   = sat_inc(hit_q);
                    state_d = S_DONE;
                end else begin
                    miss_d  = sat_inc(miss_q);
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                fill_buf_d = mem_rdata;
                rdata_d    = mem_rdata;
                state_d    = S_FILL;
            end
            S_FILL: begin
                cache_we    = 1'b1;
                cache_wdata = fill_buf_q;
                fill_en     = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            fill_buf_q <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            fill_buf_q <= fill_buf_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            if (fill_en) valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && fill_en) tag_q[lat_idx] <= lat_tag;
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ready  = ready_q;
    assign cache_addr = lat_idx;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign dbg_state  = state_q;

endmodule
